// File: rtl/uart_tx16_pkg.sv
// Shared UART framing definitions for the 16x transmitter and receiver.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] TICK_LAST  = 4'hF;
   localparam int         MAX_WIDTH  = 8;

   // Parity of a word zero-extended to MAX_WIDTH; the extra zeros do not change the XOR.
   // Modes other than odd/even (including 3) yield 0 and the parity slot is never sent.
   function automatic logic parity_of(input logic [MAX_WIDTH-1:0] data, input int mode);
      logic p;
      p = 1'b0;
      if (mode == PARITY_ODD) begin
         p = ~^data;
      end else if (mode == PARITY_EVEN) begin
         p = ^data;
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_tx16_if.sv
// Word handshake between a producer and the 16x UART transmitter.
// Latency: none (signal bundle only).
// Backpressure: producer holds tx_valid/tx_din until tx_ready is seen at a clock edge.
interface uart_tx16_if #(
   parameter int WIDTH = 8
);
   logic             tx_valid;
   logic [WIDTH-1:0] tx_din;
   logic             tx_ready;

   modport master (output tx_valid, output tx_din, input tx_ready);
   modport slave  (input tx_valid, input tx_din, output tx_ready);
endinterface

// File: rtl/uart_tx16.sv
// UART transmitter on the 16x oversample clock: start, WIDTH data LSB first, optional parity, stop bits.
// Latency: word accepted at edge N drives the start bit from edge N+1; each bit lasts 16 clocks.
// Backpressure: tx_ready only in IDLE or the final clock of the last stop bit; no queueing.
module uart_tx16
   import uart_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int STOP_BITS = 2,
   parameter int PARITY    = 2
) (
   input  logic       rx_clk,
   input  logic       rx_rst_n,
   uart_tx16_if.slave tx_if,
   output logic       tx_out,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int              BW        = $clog2(WIDTH);
   localparam logic            HAS_PAR   = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);
   localparam logic [1:0]      STOP_LAST = 2'(STOP_BITS - 1);
   localparam logic [BW-1:0]   BIT_LAST  = BW'(WIDTH - 1);

   generate
      if (WIDTH < 5 || WIDTH > MAX_WIDTH) begin : g_bad_width
         $error("uart_tx16: WIDTH must be in 5..8");
      end
      if (STOP_BITS < 1 || STOP_BITS > 3) begin : g_bad_stop
         $error("uart_tx16: STOP_BITS must be in 1..3");
      end
   endgenerate

   uart_state_e      state_q, state_d;
   logic [3:0]       tick_q, tick_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [1:0]       stop_cnt_q, stop_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             par_q, par_d;
   logic             tx_out_q, line_d;

   logic last_tick;
   logic last_stop;
   logic accept;

   assign last_tick      = (tick_q == TICK_LAST);
   // Final clock of the last stop bit: frame completes and a follow-on word may start with no gap.
   assign last_stop      = (state_q == ST_STOP) && last_tick && (stop_cnt_q == STOP_LAST);
   assign tx_if.tx_ready = (state_q == ST_IDLE) || last_stop;
   assign accept         = tx_if.tx_valid && tx_if.tx_ready;
   assign tx_done        = last_stop;
   assign tx_busy        = (state_q != ST_IDLE);
   assign tx_out         = tx_out_q;

   // Next-state, counters and the line level for the current state (registered below).
   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      line_d     = 1'b1;

      if (state_q != ST_IDLE) begin
         tick_d = tick_q + 4'd1;
      end

      case (state_q)
         ST_IDLE: begin
            line_d = 1'b1;
         end
         ST_START: begin
            line_d = 1'b0;
            if (last_tick) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            line_d = shift_q[0];
            if (last_tick) begin
               shift_d = {1'b0, shift_q[WIDTH-1:1]};
               if (bit_cnt_q == BIT_LAST) begin
                  // Cleared rather than incremented so the counter never wraps.
                  bit_cnt_d = '0;
                  state_d   = HAS_PAR ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            line_d = par_q;
            if (last_tick) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            line_d = 1'b1;
            if (last_tick) begin
               if (stop_cnt_q == STOP_LAST) begin
                  stop_cnt_d = 2'd0;
                  state_d    = ST_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Acceptance only happens in IDLE or the last stop clock; both restart a frame.
      if (accept) begin
         state_d    = ST_START;
         tick_d     = 4'd0;
         bit_cnt_d  = '0;
         stop_cnt_d = 2'd0;
         shift_d    = tx_if.tx_din;
         par_d      = parity_of(MAX_WIDTH'(tx_if.tx_din), PARITY);
      end
   end

   // State and datapath registers; reset forces the line high and drops any partial frame.
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_q    <= ST_IDLE;
         tick_q     <= 4'd0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 2'd0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_out_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_out_q   <= line_d;
      end
   end

endmodule

// File: tb/tb_uart_tx16.sv
// Bench for uart_tx16: three instances (even, odd, no parity), scoreboard of expected line patterns.
// Latency: checks start bit one clock after acceptance and tx_done on the last stop clock.
// Backpressure: exercises back-to-back acceptance and ignored mid-frame requests.
module tb_uart_tx16;
   import uart_pkg::*;

   logic       rx_clk;
   logic       rx_rst_n;
   logic [2:0] valid;
   logic [7:0] din [3];
   wire  [2:0] rdy;
   wire  [2:0] txo;
   wire  [2:0] busy;
   wire  [2:0] done;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int PAR = (g == 0) ? PARITY_EVEN : ((g == 1) ? PARITY_ODD : PARITY_NONE);
      uart_tx16_if #(.WIDTH(8)) tif ();
      assign tif.tx_valid = valid[g];
      assign tif.tx_din   = din[g];
      assign rdy[g]       = tif.tx_ready;
      uart_tx16 #(.WIDTH(8), .STOP_BITS(2), .PARITY(PAR)) u_dut (
         .rx_clk   (rx_clk),
         .rx_rst_n (rx_rst_n),
         .tx_if    (tif),
         .tx_out   (txo[g]),
         .tx_busy  (busy[g]),
         .tx_done  (done[g])
      );
   end

   initial begin
      rx_clk = 1'b0;
      forever #5 rx_clk = ~rx_clk;
   end

   always @(posedge rx_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: one entry per accepted word, holding the hand-written line pattern (slot 0 first).
   typedef struct {
      int    id;
      string exp;
      int    acc;
   } frame_t;

   frame_t sbq[$];
   frame_t cur;
   bit     mon_act = 0;
   int     k, n;
   bit     slot_bad, done_bad, hs_bad;
   logic   eb;

   // Monitor: tracks the line sample by sample from the clock after acceptance.
   always @(negedge rx_clk) begin
      if (!mon_act && sbq.size() > 0 && cyc == sbq[0].acc + 1) begin
         cur      = sbq.pop_front();
         mon_act  = 1;
         k        = 0;
         slot_bad = 0;
         done_bad = 0;
         hs_bad   = 0;
      end
      if (mon_act) begin
         n  = cur.exp.len() * 16;
         eb = (cur.exp[k/16] == 8'h31);
         if (txo[cur.id] !== eb) slot_bad = 1;
         if (done[cur.id] !== (k == n - 2)) done_bad = 1;
         if (k <= n - 2 && (rdy[cur.id] !== (k == n - 2) || busy[cur.id] !== 1'b1)) hs_bad = 1;
         if (k % 16 == 15) begin
            chk($sformatf("dut%0d acc%0d slot%0d line", cur.id, cur.acc, k / 16), {31'd0, slot_bad}, 32'd0);
            slot_bad = 0;
         end
         if (k == n - 1) begin
            chk($sformatf("dut%0d acc%0d tx_done timing", cur.id, cur.acc), {31'd0, done_bad}, 32'd0);
            chk($sformatf("dut%0d acc%0d ready/busy", cur.id, cur.acc), {31'd0, hs_bad}, 32'd0);
            mon_act = 0;
         end
         k++;
      end
   end

   // Receiver model for instance 0 (even parity, 8 data, 2 stops): mid-bit sampling.
   int         r_cnt;
   int         slot;
   bit         r_act  = 0;
   logic       r_prev = 1'b1;
   logic [7:0] r_sh   = 8'd0;
   logic       r_par  = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_word = 8'd0;
   bit         rx_perr = 0, rx_ferr = 0, perr_seen = 0;

   always @(negedge rx_clk) begin
      if (!rx_rst_n) begin
         r_act  = 0;
         r_prev = 1'b1;
      end else begin
         if (!r_act) begin
            if (r_prev && !txo[0]) begin
               r_act = 1;
               r_cnt = 0;
            end
         end else begin
            r_cnt++;
         end
         if (r_act && r_cnt % 16 == 8) begin
            slot = r_cnt / 16;
            if (slot == 0) rx_ferr = (txo[0] !== 1'b0);
            else if (slot <= 8) r_sh[slot-1] = txo[0];
            else if (slot == 9) r_par = txo[0];
            else begin
               if (txo[0] !== 1'b1) rx_ferr = 1;
               if (slot == 11) begin
                  rx_word   = r_sh;
                  rx_perr   = (r_par !== parity_of(r_sh, PARITY_EVEN));
                  perr_seen = perr_seen | rx_perr;
                  rx_cnt++;
                  r_act = 0;
               end
            end
         end
         r_prev = txo[0];
      end
   end

   task automatic send(input int id, input logic [7:0] d, input string exp,
                       input bit push, input bit hold, output int acc);
      bit     ok;
      frame_t f;
      ok  = 0;
      acc = -1;
      @(negedge rx_clk);
      valid[id] = 1'b1;
      din[id]   = d;
      for (int t = 0; t < 500 && !ok; t++) begin
         if (rdy[id]) begin
            ok  = 1;
            acc = cyc + 1;
            if (push) begin
               f.id  = id;
               f.exp = exp;
               f.acc = acc;
               sbq.push_back(f);
            end
         end else begin
            @(negedge rx_clk);
         end
      end
      chk($sformatf("dut%0d accept %0h", id, d), {31'd0, ok}, 32'd1);
      @(negedge rx_clk);
      if (!hold || !ok) valid[id] = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((mon_act || sbq.size() != 0) && t < 3000) begin
         @(negedge rx_clk);
         t++;
      end
      chk("scoreboard drained", {31'd0, (mon_act || sbq.size() != 0)}, 32'd0);
      repeat (4) @(negedge rx_clk);
   endtask

   int a1, a2, rc0;

   initial begin
      rx_rst_n = 1'b0;
      valid    = 3'b000;
      for (int i = 0; i < 3; i++) din[i] = 8'h00;
      repeat (3) @(negedge rx_clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset dut%0d tx_out", i),   {31'd0, txo[i]},  32'd1);
         chk($sformatf("reset dut%0d tx_busy", i),  {31'd0, busy[i]}, 32'd0);
         chk($sformatf("reset dut%0d tx_done", i),  {31'd0, done[i]}, 32'd0);
         chk($sformatf("reset dut%0d tx_ready", i), {31'd0, rdy[i]},  32'd1);
      end
      rx_rst_n = 1'b1;
      repeat (2) @(negedge rx_clk);

      // 0xA5 even parity: 192-clock frame, tx_done on clock 191.
      send(0, 8'hA5, "010100101011", 1, 0, a1);
      wait_idle();

      // Odd parity 0x01 / 0x03, then no-parity 0x03 (176 clocks).
      send(1, 8'h01, "010000000011", 1, 0, a1);
      wait_idle();
      send(1, 8'h03, "011000000111", 1, 0, a1);
      wait_idle();
      send(2, 8'h03, "01100000011", 1, 0, a1);
      wait_idle();

      // Back-to-back with tx_valid held high.
      send(0, 8'h00, "000000000011", 1, 1, a1);
      send(0, 8'hFF, "011111111011", 1, 0, a2);
      chk("back-to-back acceptance spacing", a2 - a1, 32'd192);
      wait_idle();

      // Asynchronous reset at clock 70 of a frame.
      send(0, 8'h55, "", 0, 0, a1);
      while (cyc < a1 + 70) @(negedge rx_clk);
      #2 rx_rst_n = 1'b0;
      #1;
      chk("midframe reset tx_out",   {31'd0, txo[0]},  32'd1);
      chk("midframe reset tx_busy",  {31'd0, busy[0]}, 32'd0);
      chk("midframe reset tx_ready", {31'd0, rdy[0]},  32'd1);
      repeat (2) @(negedge rx_clk);
      rx_rst_n = 1'b1;
      repeat (20) @(negedge rx_clk);
      chk("post reset line idle", {31'd0, txo[0]},  32'd1);
      chk("post reset not busy",  {31'd0, busy[0]}, 32'd0);
      send(0, 8'hA5, "010100101011", 1, 0, a1);
      wait_idle();

      // Mid-frame data change and extra request are ignored.
      send(0, 8'h5A, "001011010011", 1, 0, a1);
      while (cyc < a1 + 60) @(negedge rx_clk);
      valid[0] = 1'b1;
      din[0]   = 8'hFF;
      chk("midframe tx_ready low", {31'd0, rdy[0]}, 32'd0);
      @(negedge rx_clk);
      valid[0] = 1'b0;
      while (cyc < a1 + 192 + 40) @(negedge rx_clk);
      chk("ignored request: not busy", {31'd0, busy[0]}, 32'd0);
      chk("ignored request: line high", {31'd0, txo[0]}, 32'd1);
      wait_idle();

      // Loopback into the receiver model.
      rc0 = rx_cnt;
      send(0, 8'h3C, "000111100011", 1, 0, a1);
      wait_idle();
      repeat (10) @(negedge rx_clk);
      chk("loopback word count", rx_cnt - rc0, 32'd1);
      chk("loopback word", {24'd0, rx_word}, 32'h3C);
      chk("loopback parity error", {31'd0, rx_perr}, 32'd0);
      chk("loopback framing error", {31'd0, rx_ferr}, 32'd0);
      chk("parity error ever seen", {31'd0, perr_seen}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
